qbus_dma_master: RTL and testbench

QBUS bus-master cycle engine for the QSIC; it is the initiator counterpart to the switch-register slave. On an internal request it arbitrates for the bus via DMR/DMG/SACK, runs one DATI, DATO or DATOB cycle, and returns the read data or a timeout error. It sits between the QSIC's internal DMA logic and the Am2908 DAL transceiver controls. The top level owns the ZDAL/ZBS7/ZWTBT tristates.

---
 rtl/qbus_dma_master.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_qbus_dma_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_dma_master.sv
// qbus_dma_master
//   QBUS bus-master cycle engine. On an internal request it runs the bus
//   arbitration handshake (TDMR / RDMGI / TSACK), then performs one DATI,
//   DATO or DATOB cycle and reports completion (done) with optional
//   RRPLY-timeout error (err). All logic runs on the rising edge of clk20.
//
//   Optional feature: define QSIC_DMA_TIMEOUT_EN to build the RRPLY timeout
//   counter. Without it, err is tied to 0 and WAITRPLY waits indefinitely;
//   only RINIT or reset_L can end a cycle that never gets a reply.
//
// Ports
//   clk20, reset_L                : 20 MHz clock, async active-low reset
//   req, req_write, req_byte      : request strobe and cycle type
//   req_addr[21:0], req_data[15:0]: bus address and write data
//   busy, done, err, rd_data      : status and DATI result
//   dal_out, bs7_out, wtbt_out    : values presented to the DAL while DALtx=1
//   dal_in                        : DAL as received
//   DALbe_L, DALtx, DALst         : Am2908 transceiver controls
//   RSYNC, RRPLY, RDMGI, RINIT    : received bus lines (asynchronous)
//   TSYNC, TDIN, TDOUT, TDMR,
//   TSACK, TDMGO                  : transmitted bus lines (active high)
module qbus_dma_master #(
    parameter int TIMEOUT_CYC = 200
) (
    input  logic        clk20,
    input  logic        reset_L,
    input  logic        req,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [21:0] req_addr,
    input  logic [15:0] req_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rd_data,
    output logic [21:0] dal_out,
    output logic        bs7_out,
    output logic        wtbt_out,
    input  logic [21:0] dal_in,
    output logic        DALbe_L,
    output logic        DALtx,
    output logic        DALst,
    input  logic        RSYNC,
    input  logic        RRPLY,
    input  logic        RDMGI,
    input  logic        RINIT,
    output logic        TSYNC,
    output logic        TDIN,
    output logic        TDOUT,
    output logic        TDMR,
    output logic        TSACK,
    output logic        TDMGO
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DMR,
        S_GRANT,
        S_ADDR,
        S_SYNC,
        S_DATA,
        S_WAITRPLY,
        S_RDDLY,
        S_FINISH
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  hold_cnt, hold_nx;
    logic        accept;
    logic        done_q, done_nx;
    logic        rd_load;
    logic        tmo_expire;

    logic [1:0]  rsync_sr, rrply_sr, rdmgi_sr, rinit_sr;
    logic        sRSYNC, sRRPLY, sRDMGI, sRINIT;

    logic        lat_write, lat_byte;
    logic [21:0] lat_addr;
    logic [15:0] lat_data;

    logic        addr_phase, data_drive;

    // Two-flop synchronizers for the asynchronous received bus lines
    always_ff @(posedge clk20 or negedge reset_L) begin
        if (!reset_L) begin
            rsync_sr <= '0;
            rrply_sr <= '0;
            rdmgi_sr <= '0;
            rinit_sr <= '0;
        end else begin
            rsync_sr <= {rsync_sr[0], RSYNC};
            rrply_sr <= {rrply_sr[0], RRPLY};
            rdmgi_sr <= {rdmgi_sr[0], RDMGI};
            rinit_sr <= {rinit_sr[0], RINIT};
        end
    end

    assign sRSYNC = rsync_sr[1];
    assign sRRPLY = rrply_sr[1];
    assign sRDMGI = rdmgi_sr[1];
    assign sRINIT = rinit_sr[1];

    // Request fields are pure data: captured on acceptance, never reset
    always_ff @(posedge clk20) begin
        if (accept) begin
            lat_write <= req_write;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr;
            lat_data  <= req_data;
        end
    end

    always_ff @(posedge clk20 or negedge reset_L) begin
        if (!reset_L) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            done_q   <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            done_q   <= done_nx;
            if (rd_load) begin
                rd_data <= dal_in[15:0];
            end
        end
    end

`ifdef QSIC_DMA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    always_ff @(posedge clk20 or negedge reset_L) begin
        if (!reset_L) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_WAITRPLY) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (state == S_WAITRPLY && !sRRPLY && tmo_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    // The budget spans TDIN/TDOUT rising to done: expiry leaves WAITRPLY,
    // FINISH takes one cycle and done follows one cycle later, so WAITRPLY
    // gives up two cycles early.
    assign tmo_expire = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 2));
    assign err        = err_q;
`else
    // No timeout hardware; the comparison folds to constant 0.
    assign tmo_expire = (TIMEOUT_CYC < 0);
    assign err        = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        accept   = 1'b0;
        done_nx  = 1'b0;
        rd_load  = 1'b0;

        case (state)
            S_IDLE: begin
                if (req) begin
                    accept   = 1'b1;
                    hold_nx  = '0;
                    state_nx = S_DMR;
                end
            end
            S_DMR: begin
                if (sRDMGI) begin
                    state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                // Previous master must have released SYNC and RPLY
                if (!sRSYNC && !sRRPLY) begin
                    hold_nx  = '0;
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                if (hold_cnt == 2'd1) begin
                    hold_nx  = '0;
                    state_nx = S_SYNC;
                end else begin
                    hold_nx = hold_cnt + 2'd1;
                end
            end
            S_SYNC: begin
                if (hold_cnt == 2'd1) begin
                    hold_nx  = '0;
                    state_nx = S_DATA;
                end else begin
                    hold_nx = hold_cnt + 2'd1;
                end
            end
            S_DATA: begin
                // Reads use this single cycle to turn the DAL around;
                // writes hold the data two cycles before TDOUT.
                if (!lat_write || hold_cnt == 2'd1) begin
                    hold_nx  = '0;
                    state_nx = S_WAITRPLY;
                end else begin
                    hold_nx = hold_cnt + 2'd1;
                end
            end
            S_WAITRPLY: begin
                // A reply arriving on the expiry cycle takes priority
                if (sRRPLY) begin
                    hold_nx  = '0;
                    state_nx = lat_write ? S_FINISH : S_RDDLY;
                end else if (tmo_expire) begin
                    state_nx = S_FINISH;
                end
            end
            S_RDDLY: begin
                // Slave data settles two cycles after the synchronized RPLY
                if (hold_cnt == 2'd1) begin
                    rd_load  = 1'b1;
                    hold_nx  = '0;
                    state_nx = S_FINISH;
                end else begin
                    hold_nx = hold_cnt + 2'd1;
                end
            end
            S_FINISH: begin
                if (!sRRPLY) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Bus INIT abandons any cycle in progress without a done pulse
        if (state != S_IDLE && sRINIT) begin
            state_nx = S_IDLE;
            hold_nx  = '0;
            done_nx  = 1'b0;
        end
    end

    assign addr_phase = (state == S_ADDR) || (state == S_SYNC);
    assign data_drive = lat_write &&
                        ((state == S_DATA) || (state == S_WAITRPLY) || (state == S_FINISH));

    assign DALtx    = addr_phase || data_drive;
    assign DALbe_L  = !DALtx;
    assign DALst    = (hold_cnt == 2'd0) &&
                      ((state == S_ADDR) || (state == S_DATA && lat_write));
    assign dal_out  = addr_phase ? lat_addr :
                      data_drive ? {6'b0, lat_data} : '0;
    assign bs7_out  = addr_phase && (&lat_addr[21:13]);
    assign wtbt_out = addr_phase ? lat_write :
                      data_drive ? lat_byte  : 1'b0;

    assign TDMR  = (state == S_DMR);
    assign TSACK = (state == S_GRANT) || (state == S_ADDR) || (state == S_SYNC) ||
                   (state == S_DATA) || (state == S_WAITRPLY) || (state == S_RDDLY) ||
                   (state == S_FINISH);
    assign TSYNC = (state == S_SYNC) || (state == S_DATA) || (state == S_WAITRPLY) ||
                   (state == S_RDDLY) || (state == S_FINISH);
    assign TDIN  = !lat_write && ((state == S_WAITRPLY) || (state == S_RDDLY));
    assign TDOUT = lat_write && (state == S_WAITRPLY);

    // Grant passes straight through only when we have no use for it
    assign TDMGO = (state == S_IDLE && !req) ? RDMGI : 1'b0;

    assign busy = (state != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_qbus_dma_master.sv
module tb_qbus_dma_master;

    logic        clk20 = 1'b0;
    logic        reset_L;
    logic        req, req_write, req_byte;
    logic [21:0] req_addr;
    logic [15:0] req_data;
    logic        busy, done, err;
    logic [15:0] rd_data;
    logic [21:0] dal_out;
    logic        bs7_out, wtbt_out;
    logic [21:0] dal_in;
    logic        DALbe_L, DALtx, DALst;
    logic        RSYNC, RRPLY, RDMGI, RINIT;
    logic        TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO;

    qbus_dma_master dut (
        .clk20    (clk20),
        .reset_L  (reset_L),
        .req      (req),
        .req_write(req_write),
        .req_byte (req_byte),
        .req_addr (req_addr),
        .req_data (req_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rd_data  (rd_data),
        .dal_out  (dal_out),
        .bs7_out  (bs7_out),
        .wtbt_out (wtbt_out),
        .dal_in   (dal_in),
        .DALbe_L  (DALbe_L),
        .DALtx    (DALtx),
        .DALst    (DALst),
        .RSYNC    (RSYNC),
        .RRPLY    (RRPLY),
        .RDMGI    (RDMGI),
        .RINIT    (RINIT),
        .TSYNC    (TSYNC),
        .TDIN     (TDIN),
        .TDOUT    (TDOUT),
        .TDMR     (TDMR),
        .TSACK    (TSACK),
        .TDMGO    (TDMGO)
    );

    always #25 clk20 = ~clk20;

    typedef struct {
        logic        wr;
        logic        err;
        logic [15:0] rd;
        logic [21:0] addr;
        logic        bs7;
        logic        wa;
        logic        wd;
        logic [15:0] wdata;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int done_cnt = 0;

    // Responder / arbiter model state
    logic        arb_auto = 1'b0;
    logic        no_reply = 1'b0;
    logic [15:0] slave_rdata = '0;
    logic [15:0] slave_wdata = '0;
    logic [21:0] cap_addr = '0;
    logic        cap_bs7 = 1'b0, cap_wtbt_a = 1'b0, cap_wtbt_d = 1'b0;
    logic [21:0] sync_addr = '0;
    int          dst_cyc = 0, tdout_gap = 0, tdat_cyc = 0;
    logic        grant_leak = 1'b0, sack_seen = 1'b0;
    logic        tx_prev = 1'b0, tdout_prev = 1'b0, tsync_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0o%0o, expected 0o%0o", name, act, exp);
    endtask

    task automatic push(input logic wr, input logic e, input logic [15:0] rd,
                        input logic [21:0] addr, input logic bs7, input logic wa,
                        input logic wd, input logic [15:0] wdata);
        exp_t x;
        x.wr = wr; x.err = e; x.rd = rd; x.addr = addr;
        x.bs7 = bs7; x.wa = wa; x.wd = wd; x.wdata = wdata;
        sb.push_back(x);
    endtask

    task automatic run_req(input logic w, input logic b, input logic [21:0] a,
                           input logic [15:0] d);
        req_write = w; req_byte = b; req_addr = a; req_data = d;
        req = 1'b1;
        @(negedge clk20);
        req = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk20);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s: no done within %0d cycles", name, limit);
        end
    endtask

    initial forever begin
        @(posedge clk20);
        cyc++;
    end

    // Bus responder: arbiter grant, slave reply, and DAL capture
    initial forever begin
        @(negedge clk20);
        if (arb_auto) begin
            if (TSACK) RDMGI = 1'b0;
            else if (TDMR) RDMGI = 1'b1;
        end
        if ((TDIN || TDOUT) && !no_reply) begin
            if (TDIN) dal_in = {6'b0, slave_rdata};
            if (TDOUT) slave_wdata = dal_out[15:0];
            RRPLY = 1'b1;
        end else if (!TDIN && !TDOUT) begin
            RRPLY = 1'b0;
        end
        if (DALst && !TSYNC) begin
            cap_addr = dal_out; cap_bs7 = bs7_out; cap_wtbt_a = wtbt_out;
        end
        if (DALst && TSYNC) begin
            cap_wtbt_d = wtbt_out; dst_cyc = cyc;
        end
        if (TDOUT && !tdout_prev) tdout_gap = cyc - dst_cyc;
        if (TSYNC && !tsync_prev) sync_addr = dal_out;
        if ((TDIN || TDOUT) && !tx_prev) tdat_cyc = cyc;
        if (TDMGO && busy) grant_leak = 1'b1;
        if (TSACK) sack_seen = 1'b1;
        tdout_prev = TDOUT;
        tsync_prev = TSYNC;
        tx_prev    = TDIN || TDOUT;
    end

    // Scoreboard monitor: one expected entry per done pulse
    initial forever begin
        exp_t e;
        @(negedge clk20);
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1, expected no done");
            end else begin
                e = sb.pop_front();
                chk("sb_err", err, e.err);
                if (!e.wr) chk("sb_rd_data", rd_data, e.rd);
                chk("sb_addr", cap_addr, e.addr);
                chk("sb_bs7", cap_bs7, e.bs7);
                chk("sb_wtbt_addr", cap_wtbt_a, e.wa);
                if (e.wr) begin
                    chk("sb_wtbt_data", cap_wtbt_d, e.wd);
                    chk("sb_wdata", slave_wdata, e.wdata);
                end
            end
        end
    end

    initial begin
        int d0;
        logic seen;
        reset_L = 1'b0; req = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_data = '0; dal_in = '0;
        RSYNC = 1'b0; RRPLY = 1'b0; RDMGI = 1'b0; RINIT = 1'b0;
        repeat (3) @(negedge clk20);

        chk("rst_tbus", {TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO}, 0);
        chk("rst_dal_ctl", {DALtx, DALst, DALbe_L}, 3'b001);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_dal_out", dal_out, 0);
        reset_L = 1'b1;
        repeat (3) @(negedge clk20);

        // Idle grant passthrough
        RDMGI = 1'b1; #1;
        chk("tdmgo_pass", TDMGO, 1);
        @(negedge clk20);
        RDMGI = 1'b0; #1;
        chk("tdmgo_drop", TDMGO, 0);
        @(negedge clk20);
        arb_auto = 1'b1;

        // DATI of the 22-bit I/O page address 17777570 (18-bit 777570)
        slave_rdata = 16'o123456; grant_leak = 1'b0; sack_seen = 1'b0;
        push(1'b0, 1'b0, 16'o123456, 22'o17777570, 1'b1, 1'b0, 1'b0, 16'o0);
        run_req(1'b0, 1'b0, 22'o17777570, 16'o0);
        wait_done(100, "dati_done");
        chk("dati_no_grant_leak", grant_leak, 0);
        chk("dati_sack_seen", sack_seen, 1);
        chk("dati_sync_addr", sync_addr, 22'o17777570);
        repeat (2) @(negedge clk20);

        // DATO
        push(1'b1, 1'b0, 16'o0, 22'o001000, 1'b0, 1'b1, 1'b0, 16'o000777);
        run_req(1'b1, 1'b0, 22'o001000, 16'o000777);
        wait_done(100, "dato_done");
        chk("dato_tdout_gap_ge2", (tdout_gap >= 2), 1);
        repeat (2) @(negedge clk20);

        // DATOB to odd byte
        push(1'b1, 1'b0, 16'o0, 22'o001001, 1'b0, 1'b1, 1'b1, 16'o000252);
        run_req(1'b1, 1'b1, 22'o001001, 16'o000252);
        wait_done(100, "datob_done");
        chk("datob_addr_lane", cap_addr[0], 1);
        repeat (2) @(negedge clk20);

        // Prior master still holding SYNC
        RSYNC = 1'b1; slave_rdata = 16'o052525;
        push(1'b0, 1'b0, 16'o052525, 22'o004000, 1'b0, 1'b0, 1'b0, 16'o0);
        run_req(1'b0, 1'b0, 22'o004000, 16'o0);
        repeat (20) @(negedge clk20);
        chk("rsync_hold_sack", TSACK, 1);
        chk("rsync_hold_no_addr", DALtx, 0);
        RSYNC = 1'b0;
        wait_done(100, "rsync_done");
        repeat (2) @(negedge clk20);

        // req held through done restarts immediately
        slave_rdata = 16'o111111;
        push(1'b0, 1'b0, 16'o111111, 22'o000100, 1'b0, 1'b0, 1'b0, 16'o0);
        push(1'b0, 1'b0, 16'o111111, 22'o000100, 1'b0, 1'b0, 1'b0, 16'o0);
        req_write = 1'b0; req_byte = 1'b0; req_addr = 22'o000100; req_data = '0;
        req = 1'b1;
        wait_done(100, "held_first_done");
        @(negedge clk20);
        chk("req_held_restart", busy, 1);
        req = 1'b0;
        wait_done(100, "held_second_done");
        repeat (2) @(negedge clk20);

        // No reply from slave
        no_reply = 1'b1;
`ifdef QSIC_DMA_TIMEOUT_EN
        push(1'b0, 1'b1, 16'o111111, 22'o002000, 1'b0, 1'b0, 1'b0, 16'o0);
        run_req(1'b0, 1'b0, 22'o002000, 16'o0);
        wait_done(400, "tmo_done");
        chk("tmo_latency", cyc - tdat_cyc, 200);
        chk("tmo_tbus_idle", {TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO}, 0);
        repeat (2) @(negedge clk20);
`else
        d0 = done_cnt;
        run_req(1'b0, 1'b0, 22'o002000, 16'o0);
        repeat (1000) @(negedge clk20);
        chk("no_tmo_no_done", done_cnt - d0, 0);
        chk("no_tmo_still_tdin", {busy, TDIN}, 2'b11);
        RINIT = 1'b1;
        repeat (3) @(negedge clk20);
        RINIT = 1'b0;
        repeat (4) @(negedge clk20);
        chk("no_tmo_init_exit", busy, 0);
`endif

        // INIT during WAITRPLY
        d0 = done_cnt;
        run_req(1'b0, 1'b0, 22'o003000, 16'o0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk20);
            if (TDIN) begin
                seen = 1'b1;
                break;
            end
        end
        chk("init_reached_tdin", seen, 1);
        RINIT = 1'b1;
        repeat (3) @(negedge clk20);
        chk("init_tbus", {TSYNC, TDIN, TSACK}, 0);
        chk("init_busy", busy, 0);
        RINIT = 1'b0;
        repeat (10) @(negedge clk20);
        chk("init_no_done", done_cnt - d0, 0);
        no_reply = 1'b0;

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
